fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter LEN_W, default 8, width of burst length field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port len  input  LEN_W  number of words in the burst; sampled with start.
REQ-007 SHALL have port busy  output  1  high while a burst is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-009 SHALL have port fifo_empty  input  1  empty flag of the upstream synchronous FIFO.
REQ-010 SHALL have port fifo_r_en  output  1  read enable to the upstream FIFO.
REQ-011 SHALL have port fifo_data  input  WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-012 SHALL have port m_valid  output  1  output word valid.
REQ-013 SHALL have port m_ready  input  1  downstream accepts the word when high with m_valid.
REQ-014 SHALL have port m_data  output  WIDTH  output word.
REQ-015 SHALL have port m_last  output  1  high with m_valid on the final word of the burst.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start with len!=0; IDLE->DONE on start with len==0; RUN->DONE on the handshake of the final word; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL assert busy in RUN and DONE, and done only in DONE.
REQ-018 SHALL ignore start when not in IDLE.
REQ-019 SHALL assert fifo_r_en only when state is RUN, fifo_empty==0, issued-read count < len, and (buffer occupancy + reads in flight) < 4.
REQ-020 SHALL capture fifo_data into a 4-entry output buffer at the edge ending the cycle after each cycle in which fifo_r_en was high.
REQ-021 SHALL drive m_valid from buffer non-empty and m_data from the buffer head; a handshake (m_valid & m_ready) pops the head.
REQ-022 SHALL hold m_data and m_valid stable while m_valid & !m_ready.
REQ-023 SHALL sustain one word per cycle when fifo_empty==0 and m_ready==1 continuously.
REQ-024 SHALL give latency: start at cycle T, first fifo_r_en at T+1, first m_valid at T+3.
REQ-025 SHALL issue exactly len reads and emit exactly len words per burst, words in FIFO order.
REQ-026 SHALL assert m_last only on word number len (1-based).
REQ-027 SHALL treat len as unsigned; maximum burst 2^LEN_W-1 words; counters SHALL not wrap within a burst.
REQ-028 SHALL handle simultaneous capture and pop in one cycle with occupancy unchanged.

Reset
REQ-029 SHALL on rst force state IDLE, busy=0, done=0, fifo_r_en=0, m_valid=0, m_last=0, m_data=0, counters and buffer pointers zero.
REQ-030 SHALL on rst mid-burst discard buffered and in-flight words; no read data SHALL be captured in the cycle following rst.
REQ-031 SHALL take priority of rst over start and all handshakes in the same cycle.

Configuration
REQ-032 SHALL, with macro FIFO_BURST_READER_PERF_EN defined, add port starve_cnt output 16, counting RUN cycles where fifo_empty==1 and issued count < len, saturating at 16'hFFFF, cleared on accepted start and on rst.
REQ-033 SHALL, without FIFO_BURST_READER_PERF_EN, omit starve_cnt and its logic with all other behaviour identical.

Verification
REQ-034 SHALL cover: FIFO preloaded 0x0001..0x0005, len=5, m_ready=1 -> m_data 0x0001..0x0005 on consecutive cycles from T+3, m_last with 0x0005, done one cycle later.
REQ-035 SHALL cover: len=0 start -> no fifo_r_en, no m_valid, done at T+1, busy T+1 only.
REQ-036 SHALL cover: len=8, m_ready low for 6 cycles after first m_valid -> at most 4 reads outstanding/buffered, m_data held at first word, all 8 words delivered in order afterwards.
REQ-037 SHALL cover: FIFO empty for 10 cycles after start, then 3 words written, len=3 -> no fifo_r_en while empty, 3 words delivered, starve_cnt=10 when PERF_EN defined.
REQ-038 SHALL cover: rst asserted after 2 of 6 words handshaked -> all outputs reset next cycle, new start with len=2 delivers next FIFO words correctly.
REQ-039 SHALL cover: start pulsed during RUN with different len -> ignored, original burst length respected.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls a burst of `len` words out of an upstream
// synchronous FIFO (one-cycle read latency) and presents them on a
// valid/ready stream through a 4-entry skid buffer, flagging the last word.
//
// Optional build macro FIFO_BURST_READER_PERF_EN adds the starve_cnt port:
// number of RUN cycles spent waiting on an empty FIFO while reads are still
// owed, saturating, cleared on rst and on an accepted start.
module fifo_burst_reader #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   input  logic             fifo_empty,
   output logic             fifo_r_en,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
`ifdef FIFO_BURST_READER_PERF_EN
   ,
   output logic [15:0]      starve_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);
   localparam logic [LEN_W:0]   CNT_ONE  = (LEN_W + 1)'(1'b1);
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;    // reads issued this burst
   logic [LEN_W-1:0] out_cnt_q, out_cnt_d;  // words handed downstream
   logic             pend_q, pend_d;        // a read was issued last cycle
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [2:0]       occ_q, occ_d;          // buffer occupancy 0..4
   logic [WIDTH-1:0] obuf_q [4];
   logic [WIDTH-1:0] obuf_d [4];

   logic             start_acc_s;
   logic             rd_more_s;
   logic [3:0]       inflight_s;
   logic             rd_en_s;
   logic             m_valid_s;
   logic             pop_s;
   logic             last_s;

   // Handshake and read-enable decode shared by every other block.
   always_comb begin
      start_acc_s = (state_q == ST_IDLE) & start;
      rd_more_s   = (rd_cnt_q < len_q);
      inflight_s  = {1'b0, occ_q} + {3'b000, pend_q};
      // rst gates the read so no FIFO word is consumed and then thrown away
      // in the reset cycle.
      rd_en_s     = ~rst & (state_q == ST_RUN) & ~fifo_empty & rd_more_s
                    & (inflight_s < 4'd4);
      m_valid_s   = (occ_q != 3'd0);
      pop_s       = m_valid_s & m_ready;
      // Widened compare so a 2^LEN_W-1 word burst cannot wrap.
      last_s      = (({1'b0, out_cnt_q} + CNT_ONE) == {1'b0, len_q});
   end

   // Burst state machine next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len == LEN_ZERO) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (pop_s && last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Burst length and read/output counters; all restart on an accepted start.
   always_comb begin
      len_d     = start_acc_s ? len : len_q;
      rd_cnt_d  = start_acc_s ? LEN_ZERO :
                  (rd_en_s ? (rd_cnt_q + LEN_ONE) : rd_cnt_q);
      out_cnt_d = start_acc_s ? LEN_ZERO :
                  (pop_s ? (out_cnt_q + LEN_ONE) : out_cnt_q);
      pend_d    = rd_en_s;
   end

   // Output buffer: capture the word returned one cycle after each read,
   // pop the head on a handshake; both in one cycle leaves occupancy as is.
   always_comb begin
      wr_ptr_d = pend_q ? (wr_ptr_q + 2'd1) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + 2'd1) : rd_ptr_q;
      case ({pend_q, pop_s})
         2'b10:   occ_d = occ_q + 3'd1;
         2'b01:   occ_d = occ_q - 3'd1;
         default: occ_d = occ_q;
      endcase
      for (int i = 0; i < 4; i++) begin
         obuf_d[i] = (pend_q && (wr_ptr_q == 2'(i))) ? fifo_data : obuf_q[i];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter, pointer and in-flight registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= LEN_ZERO;
         rd_cnt_q  <= LEN_ZERO;
         out_cnt_q <= LEN_ZERO;
         pend_q    <= 1'b0;
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         occ_q     <= 3'd0;
      end else begin
         len_q     <= len_d;
         rd_cnt_q  <= rd_cnt_d;
         out_cnt_q <= out_cnt_d;
         pend_q    <= pend_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
      end
   end

   // Buffer storage; cleared on reset so m_data reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            obuf_q[i] <= DATA_ZERO;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            obuf_q[i] <= obuf_d[i];
         end
      end
   end

`ifdef FIFO_BURST_READER_PERF_EN
   logic [15:0] starve_q, starve_d;

   // Starvation counter next value: saturating count of empty-FIFO stalls.
   always_comb begin
      if (start_acc_s) begin
         starve_d = 16'h0000;
      end else if ((state_q == ST_RUN) && fifo_empty && rd_more_s
                   && (starve_q != 16'hFFFF)) begin
         starve_d = starve_q + 16'h0001;
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= 16'h0000;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign starve_cnt = starve_q;
`endif

   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign fifo_r_en = rd_en_s;
   assign m_valid   = m_valid_s;
   assign m_data    = obuf_q[rd_ptr_q];
   assign m_last    = m_valid_s & last_s;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural upstream FIFO.
// Inputs are driven and outputs observed at the falling edge; "cycle T+k"
// is observed k falling edges after start was raised.
module tb_fifo_burst_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        done;
   logic        fifo_empty;
   logic        fifo_r_en;
   logic [15:0] fifo_data = 16'h0000;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_last;
`ifdef FIFO_BURST_READER_PERF_EN
   logic [15:0] starve_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural upstream FIFO
   logic [15:0] fmem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_r_en && !fifo_empty) begin
         fifo_data <= fmem[rd_ptr[5:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   always #5 clk = ~clk;

   fifo_burst_reader #(.WIDTH(16), .LEN_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .busy(busy), .done(done),
      .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_data(fifo_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef FIFO_BURST_READER_PERF_EN
      , .starve_cnt(starve_cnt)
`endif
   );

   task automatic push(input logic [15:0] v);
      fmem[wr_ptr[5:0]] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len = 8'd0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({busy, done, fifo_r_en, m_valid, m_last} !== 5'b00000) begin
         n_bad++; $display("FAIL reset_flags got %b expected 00000", {busy, done, fifo_r_en, m_valid, m_last});
      end
      n_cmp++; if (m_data !== 16'h0000) begin
         n_bad++; $display("FAIL reset_data got %h expected 0000", m_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int base = rd_ptr;
      for (int v = 1; v <= 5; v++) push(16'(v));
      start = 1'b1; len = 8'd5; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;                      // T+1
      n_cmp++; if ({fifo_r_en, busy, m_valid} !== 3'b110) begin
         n_bad++; $display("FAIL basic_t1 got r_en/busy/valid %b expected 110", {fifo_r_en, busy, m_valid});
      end
      @(negedge clk);                                    // T+2
      n_cmp++; if (m_valid !== 1'b0) begin
         n_bad++; $display("FAIL basic_t2_valid got %b expected 0", m_valid);
      end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);                                 // T+2+k
         n_cmp++; if ({m_valid, m_data, m_last} !== {1'b1, 16'(k), (k == 5)}) begin
            n_bad++; $display("FAIL basic_word%0d got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, m_valid, m_data, m_last, 16'(k), (k == 5));
         end
      end
      @(negedge clk);                                    // T+8
      n_cmp++; if ({done, busy, m_valid} !== 3'b110) begin
         n_bad++; $display("FAIL basic_done got done/busy/valid %b expected 110", {done, busy, m_valid});
      end
      @(negedge clk);                                    // T+9
      n_cmp++; if ({done, busy} !== 2'b00) begin
         n_bad++; $display("FAIL basic_idle got done/busy %b expected 00", {done, busy});
      end
      n_cmp++; if ((rd_ptr - base) !== 5) begin
         n_bad++; $display("FAIL basic_reads got %0d expected 5", rd_ptr - base);
      end
   endtask

   task automatic test_zero_len();
      int base = rd_ptr;
      start = 1'b1; len = 8'd0;
      @(negedge clk); start = 1'b0;                      // T+1
      n_cmp++; if ({done, busy, fifo_r_en, m_valid} !== 4'b1100) begin
         n_bad++; $display("FAIL zero_t1 got done/busy/r_en/valid %b expected 1100", {done, busy, fifo_r_en, m_valid});
      end
      @(negedge clk);                                    // T+2
      n_cmp++; if ({done, busy, m_valid} !== 3'b000) begin
         n_bad++; $display("FAIL zero_t2 got done/busy/valid %b expected 000", {done, busy, m_valid});
      end
      n_cmp++; if (rd_ptr !== base) begin
         n_bad++; $display("FAIL zero_reads got %0d expected 0", rd_ptr - base);
      end
   endtask

   task automatic test_backpressure();
      int base = rd_ptr;
      int idx = 0;
      for (int v = 0; v < 8; v++) push(16'h0010 + 16'(v));
      m_ready = 1'b0; start = 1'b1; len = 8'd8;
      @(negedge clk); start = 1'b0;                      // T+1
      repeat (2) @(negedge clk);                         // T+3
      for (int s = 0; s < 6; s++) begin
         n_cmp++; if ({m_valid, m_data} !== {1'b1, 16'h0010}) begin
            n_bad++; $display("FAIL bp_hold s=%0d got v=%b d=%h expected v=1 d=0010", s, m_valid, m_data);
         end
         n_cmp++; if ((rd_ptr - base) > 4) begin
            n_bad++; $display("FAIL bp_outstanding s=%0d got %0d expected <=4", s, rd_ptr - base);
         end
         @(negedge clk);
      end
      n_cmp++; if ((rd_ptr - base) !== 4) begin
         n_bad++; $display("FAIL bp_reads_stalled got %0d expected 4", rd_ptr - base);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         if (m_valid && m_ready) begin
            n_cmp++; if ({m_data, m_last} !== {16'h0010 + 16'(idx), (idx == 7)}) begin
               n_bad++; $display("FAIL bp_word%0d got d=%h l=%b expected d=%h l=%b", idx, m_data, m_last, 16'h0010 + 16'(idx), (idx == 7));
            end
            idx++;
         end
         @(negedge clk);
      end
      n_cmp++; if (idx !== 8) begin
         n_bad++; $display("FAIL bp_count got %0d expected 8", idx);
      end
      n_cmp++; if (done !== 1'b1) begin
         n_bad++; $display("FAIL bp_done got %b expected 1", done);
      end
      n_cmp++; if ((rd_ptr - base) !== 8) begin
         n_bad++; $display("FAIL bp_reads got %0d expected 8", rd_ptr - base);
      end
      @(negedge clk);
   endtask

   task automatic test_starve();
      int idx = 0;
      start = 1'b1; len = 8'd3; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;                      // T+1
      for (int c = 1; c <= 10; c++) begin
         n_cmp++; if ({fifo_r_en, busy} !== 2'b01) begin
            n_bad++; $display("FAIL starve_no_read c=%0d got r_en/busy %b expected 01", c, {fifo_r_en, busy});
         end
         @(negedge clk);
      end
      for (int v = 0; v < 3; v++) push(16'h0020 + 16'(v)); // T+11
      for (int c = 0; c < 20 && idx < 3; c++) begin
         if (m_valid && m_ready) begin
            n_cmp++; if ({m_data, m_last} !== {16'h0020 + 16'(idx), (idx == 2)}) begin
               n_bad++; $display("FAIL starve_word%0d got d=%h l=%b expected d=%h l=%b", idx, m_data, m_last, 16'h0020 + 16'(idx), (idx == 2));
            end
            idx++;
         end
         @(negedge clk);
      end
      n_cmp++; if (idx !== 3) begin
         n_bad++; $display("FAIL starve_count got %0d expected 3", idx);
      end
`ifdef FIFO_BURST_READER_PERF_EN
      n_cmp++; if (starve_cnt !== 16'd10) begin
         n_bad++; $display("FAIL starve_cnt got %0d expected 10", starve_cnt);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int base = rd_ptr;
      int idx = 0;
      for (int v = 0; v < 6; v++) push(16'h0030 + 16'(v));
      start = 1'b1; len = 8'd6; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;                      // T+1
      repeat (2) @(negedge clk);                         // T+3
      n_cmp++; if ({m_valid, m_data} !== {1'b1, 16'h0030}) begin
         n_bad++; $display("FAIL rstmid_w0 got v=%b d=%h expected v=1 d=0030", m_valid, m_data);
      end
      @(negedge clk);                                    // T+4
      n_cmp++; if ({m_valid, m_data} !== {1'b1, 16'h0031}) begin
         n_bad++; $display("FAIL rstmid_w1 got v=%b d=%h expected v=1 d=0031", m_valid, m_data);
      end
      @(negedge clk);                                    // T+5
      rst = 1'b1; m_ready = 1'b0;
      @(negedge clk);                                    // T+6
      n_cmp++; if ({busy, done, fifo_r_en, m_valid, m_last, m_data} !== 21'd0) begin
         n_bad++; $display("FAIL rstmid_outputs got b/d/r/v/l=%b data=%h expected all zero", {busy, done, fifo_r_en, m_valid, m_last}, m_data);
      end
      n_cmp++; if ((rd_ptr - base) !== 4) begin
         n_bad++; $display("FAIL rstmid_reads got %0d expected 4", rd_ptr - base);
      end
      rst = 1'b0; start = 1'b1; len = 8'd2; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 20 && idx < 2; c++) begin
         if (m_valid && m_ready) begin
            n_cmp++; if ({m_data, m_last} !== {16'h0034 + 16'(idx), (idx == 1)}) begin
               n_bad++; $display("FAIL rstmid_word%0d got d=%h l=%b expected d=%h l=%b", idx, m_data, m_last, 16'h0034 + 16'(idx), (idx == 1));
            end
            idx++;
         end
         @(negedge clk);
      end
      n_cmp++; if (idx !== 2) begin
         n_bad++; $display("FAIL rstmid_count got %0d expected 2", idx);
      end
      n_cmp++; if ((rd_ptr - base) !== 6) begin
         n_bad++; $display("FAIL rstmid_total_reads got %0d expected 6", rd_ptr - base);
      end
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int base = rd_ptr;
      int idx = 0;
      for (int v = 0; v < 5; v++) push(16'h0040 + 16'(v));
      start = 1'b1; len = 8'd3; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;                      // T+1
      @(negedge clk); start = 1'b1; len = 8'd7;          // T+2, mid-burst
      @(negedge clk); start = 1'b0; len = 8'd0;          // T+3
      for (int c = 0; c < 20 && idx < 3; c++) begin
         if (m_valid && m_ready) begin
            n_cmp++; if ({m_data, m_last} !== {16'h0040 + 16'(idx), (idx == 2)}) begin
               n_bad++; $display("FAIL ign_word%0d got d=%h l=%b expected d=%h l=%b", idx, m_data, m_last, 16'h0040 + 16'(idx), (idx == 2));
            end
            idx++;
         end
         @(negedge clk);
      end
      n_cmp++; if ({idx == 3, done} !== 2'b11) begin
         n_bad++; $display("FAIL ign_end got words=%0d done=%b expected words=3 done=1", idx, done);
      end
      repeat (4) @(negedge clk);
      n_cmp++; if ({busy, m_valid, fifo_r_en} !== 3'b000) begin
         n_bad++; $display("FAIL ign_idle got busy/valid/r_en %b expected 000", {busy, m_valid, fifo_r_en});
      end
      n_cmp++; if ((rd_ptr - base) !== 3) begin
         n_bad++; $display("FAIL ign_reads got %0d expected 3", rd_ptr - base);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_starve();
      test_reset_mid();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
